// File: rtl/julia_pkg.sv
// Shared definitions for the Julia frame sequencer: state encoding, counter
// width and default coordinate fixed-point format.
package julia_pkg;

  localparam int COUNT_W    = 13;
  localparam int FLOAT_BIAS = 127;
  localparam int FIX_W_DEF  = 24;
  localparam int FRAC_DEF   = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fix_to_float.sv
// Combinational signed fixed-point to IEEE-754 single conversion; the mantissa
// is truncated, and zero maps to +0.0.
module fix_to_float
  import julia_pkg::*;
#(
  parameter int FIX_W = FIX_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [FIX_W-1:0] fix_in,
  output logic [31:0]      float_out
);

  logic [FIX_W-1:0]    mag;
  logic [7:0]          lead;
  logic [7:0]          shamt;
  logic [7:0]          exp_field;
  logic [FIX_W+22:0]   ext;
  logic [22:0]         mant;

  // The most-negative input negates to itself, which read unsigned is exactly
  // its magnitude 2^(FIX_W-1).
  always_comb begin
    mag  = fix_in[FIX_W-1] ? (~fix_in + 1'b1) : fix_in;
    lead = '0;
    for (int i = 0; i < FIX_W; i++) begin
      if (mag[i]) lead = 8'(i);
    end
    shamt     = 8'(FIX_W - 1) - lead;
    ext       = {mag, 23'b0} << shamt;
    mant      = ext[FIX_W+21 -: 23];
    exp_field = 8'(FLOAT_BIAS - FRAC) + lead;
    float_out = (mag == '0) ? 32'h0 : {fix_in[FIX_W-1], exp_field, mant};
  end

endmodule

// File: rtl/julia_frame_sequencer.sv
// Frame sequencer for julia_iteration: walks the pixel grid, runs the shared
// iteration counter per pixel and hands each colour to the frame writer.
module julia_frame_sequencer
  import julia_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COUNT_MAX  = 8191,
  parameter int CLEAR_CYC  = 2,
  parameter int SETTLE_CYC = 2,
  parameter int FIX_W      = FIX_W_DEF,
  parameter int FRAC       = FRAC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIX_W-1:0]   cfg_x0,
  input  logic [FIX_W-1:0]   cfg_y0,
  input  logic [FIX_W-1:0]   cfg_dx,
  input  logic [FIX_W-1:0]   cfg_dy,
  output logic               aclr,
  output logic [COUNT_W-1:0] count,
  output logic [31:0]        rZ,
  output logic [31:0]        iZ,
  input  logic [7:0]         red_in,
  input  logic [7:0]         blue_in,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic [7:0]         pix_red,
  output logic [7:0]         pix_blue,
  output logic               busy,
  output logic               done
);

  localparam logic [COUNT_W-1:0] CNT_LAST    = COUNT_W'(COUNT_MAX);
  localparam logic [7:0]         CLEAR_LAST  = 8'(CLEAR_CYC - 1);
  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [9:0]         X_LAST      = 10'(H_RES - 1);
  localparam logic [8:0]         Y_LAST      = 9'(V_RES - 1);

  state_t             state_q, state_d;
  logic [7:0]         cyc_q, cyc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               aclr_q, aclr_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FIX_W-1:0]   x0_q, x0_d;
  logic [FIX_W-1:0]   dx_q, dx_d;
  logic [FIX_W-1:0]   dy_q, dy_d;
  logic [FIX_W-1:0]   x_acc_q, x_acc_d;
  logic [FIX_W-1:0]   y_acc_q, y_acc_d;
  logic [31:0]        rz_q, rz_d, rz_conv;
  logic [31:0]        iz_q, iz_d, iz_conv;
  logic [9:0]         pix_x_q, pix_x_d;
  logic [8:0]         pix_y_q, pix_y_d;
  logic [7:0]         red_q, red_d;
  logic [7:0]         blue_q, blue_d;

  fix_to_float #(.FIX_W(FIX_W), .FRAC(FRAC)) u_conv_re (.fix_in(x_acc_q), .float_out(rz_conv));
  fix_to_float #(.FIX_W(FIX_W), .FRAC(FRAC)) u_conv_im (.fix_in(y_acc_q), .float_out(iz_conv));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    count_d = count_q;
    aclr_d  = 1'b0;
    valid_d = valid_q;
    x0_d    = x0_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    rz_d    = rz_q;
    iz_d    = iz_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    red_d   = red_q;
    blue_d  = blue_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = cfg_x0;
          dx_d    = cfg_dx;
          dy_d    = cfg_dy;
          x_acc_d = cfg_x0;
          y_acc_d = cfg_y0;
          pix_x_d = '0;
          pix_y_d = '0;
          count_d = '0;
          cyc_d   = '0;
          aclr_d  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      // The start value is re-registered every CLEAR cycle; the accumulators
      // do not move here, so rZ/iZ settle after the first edge.
      ST_CLEAR: begin
        count_d = '0;
        rz_d    = rz_conv;
        iz_d    = iz_conv;
        if (cyc_q == CLEAR_LAST) begin
          cyc_d   = '0;
          state_d = ST_RUN;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (count_q == CNT_LAST) begin
          cyc_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          red_d   = red_in;
          blue_d  = blue_in;
          valid_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_WRITE: begin
        if (pix_ready) begin
          valid_d = 1'b0;
          count_d = '0;
          cyc_d   = '0;
          if (pix_x_q < X_LAST) begin
            pix_x_d = pix_x_q + 10'd1;
            x_acc_d = x_acc_q + dx_q;
            aclr_d  = 1'b1;
            state_d = ST_CLEAR;
          end else if (pix_y_q < Y_LAST) begin
            pix_x_d = '0;
            x_acc_d = x0_q;
            pix_y_d = pix_y_q + 9'd1;
            y_acc_d = y_acc_q + dy_q;
            aclr_d  = 1'b1;
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      count_q <= '0;
      aclr_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_acc_q <= '0;
      y_acc_q <= '0;
      rz_q    <= '0;
      iz_q    <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      red_q   <= '0;
      blue_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      count_q <= count_d;
      aclr_q  <= aclr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x0_q    <= x0_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_acc_q <= x_acc_d;
      y_acc_q <= y_acc_d;
      rz_q    <= rz_d;
      iz_q    <= iz_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      red_q   <= red_d;
      blue_q  <= blue_d;
    end
  end

  assign aclr      = aclr_q;
  assign count     = count_q;
  assign rZ        = rz_q;
  assign iZ        = iz_q;
  assign pix_valid = valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_red   = red_q;
  assign pix_blue  = blue_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_julia_frame_sequencer.sv
// Self-checking bench for julia_frame_sequencer on a 2x2 grid, checked against
// a per-pixel timeline and a real-arithmetic float model.
module tb_julia_frame_sequencer;

  localparam int H_RES        = 2;
  localparam int V_RES        = 2;
  localparam int NPIX         = H_RES * V_RES;
  localparam int COUNT_MAX    = 8191;
  localparam int CLEAR_CYC    = 2;
  localparam int SETTLE_CYC   = 2;
  localparam int WRITE_PH     = CLEAR_CYC + COUNT_MAX + 1 + SETTLE_CYC;
  localparam int FRAME_BUDGET = NPIX * (WRITE_PH + 60) + 50;

  logic        clk, rst, start;
  logic [23:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
  logic        aclr;
  logic [12:0] count;
  logic [31:0] rZ, iZ;
  logic [7:0]  red_in, blue_in;
  logic        pix_valid, pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_red, pix_blue;
  logic        busy, done;

  int total;
  int bad;

  julia_frame_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .COUNT_MAX(COUNT_MAX),
    .CLEAR_CYC(CLEAR_CYC), .SETTLE_CYC(SETTLE_CYC), .FIX_W(24), .FRAC(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .aclr(aclr), .count(count), .rZ(rZ), .iZ(iZ),
    .red_in(red_in), .blue_in(blue_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_red(pix_red), .pix_blue(pix_blue),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value of the Q3.20 coordinate as a real, normalised into [1,2) by halving
  // or doubling; the exponent and fraction then give the float32 fields.
  function automatic logic [31:0] model_float(input logic [23:0] fx);
    real m;
    int  e;
    int  v;
    int  mant;
    if (fx == 24'h0) return 32'h0;
    v = int'($signed(fx));
    m = $itor(v < 0 ? -v : v) / 1048576.0;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    mant = $rtoi((m - 1.0) * 8388608.0);
    return {fx[23], 8'(127 + e), 23'(mant)};
  endfunction

  task automatic test_reset();
    int  waited;
    int  stray;
    bit  found;
    @(negedge clk);
    total++;
    if ({aclr, count, pix_valid, busy, done} !== 17'h0) begin
      bad++;
      $display("FAIL reset_initial: got ctrl=%h need 0", {aclr, count, pix_valid, busy, done});
    end
    rst = 1'b1;
    cfg_x0 = 24'($urandom) | 24'h1;
    cfg_y0 = 24'($urandom) | 24'h1;
    cfg_dx = 24'($urandom);
    cfg_dy = 24'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (waited = 0; waited < 400 && !found; waited++) begin
      if (count == 13'd100) found = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_wait_count100: got count=%0d need 100 within 400 cycles", count);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({aclr, count, pix_valid, busy, done} !== 17'h0) begin
      bad++;
      $display("FAIL reset_async_ctrl: got %h need 0", {aclr, count, pix_valid, busy, done});
    end
    total++;
    if ({rZ, iZ} !== 64'h0) begin
      bad++;
      $display("FAIL reset_async_z: got rZ=%h iZ=%h need 0", rZ, iZ);
    end
    total++;
    if ({pix_x, pix_y, pix_red, pix_blue} !== 35'h0) begin
      bad++;
      $display("FAIL reset_async_pixel: got x=%0d y=%0d r=%h b=%h need 0", pix_x, pix_y, pix_red, pix_blue);
    end
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      stray += int'(pix_valid) + int'(done) + int'(busy);
    end
    pix_ready = 1'b0;
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL post_reset_idle: got %0d active samples need 0", stray);
    end
  endtask

  task automatic test_conversion();
    logic [23:0] xs [7];
    logic [23:0] ys [7];
    logic [31:0] ers [7];
    logic [31:0] eis [7];
    xs[0] = 24'h100000; ys[0] = 24'hF80000; ers[0] = 32'h3F800000; eis[0] = 32'hBF000000;
    xs[1] = 24'h000000; ys[1] = 24'h000000; ers[1] = 32'h00000000; eis[1] = 32'h00000000;
    xs[2] = 24'h800000; ys[2] = 24'h000001; ers[2] = 32'hC1000000; eis[2] = 32'h35800000;
    for (int k = 3; k < 7; k++) begin
      xs[k]  = 24'($urandom);
      ys[k]  = 24'($urandom);
      ers[k] = model_float(xs[k]);
      eis[k] = model_float(ys[k]);
    end
    for (int k = 0; k < 7; k++) begin
      cfg_x0 = xs[k];
      cfg_y0 = ys[k];
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      total++;
      if (rZ !== ers[k]) begin
        bad++;
        $display("FAIL conv_rz[%0d] x0=%h: got %h need %h", k, xs[k], rZ, ers[k]);
      end
      total++;
      if (iZ !== eis[k]) begin
        bad++;
        $display("FAIL conv_iz[%0d] y0=%h: got %h need %h", k, ys[k], iZ, eis[k]);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
  endtask

  // One whole frame. stress adds random backpressure (5-cycle hold on the first
  // pixel) and a start pulse with fresh config during the first pixel's RUN.
  task automatic test_frame(input bit stress);
    logic [23:0] x0, y0, dx, dy;
    logic [31:0] exp_rz, exp_iz;
    logic [31:0] step_rz [2];
    logic [7:0]  exp_red, exp_blue;
    logic [12:0] exp_count;
    int          ph, pix, post, aclr_seen, done_seen, err_pix, valid_cyc;
    bit          finished;
    string       err_msg, tag;
    tag        = stress ? "stress" : "seq";
    step_rz[0] = 32'hBF800000;
    step_rz[1] = 32'hBF400000;
    x0 = stress ? 24'($urandom) : 24'hF00000;
    dx = stress ? 24'($urandom) : 24'h040000;
    y0 = 24'($urandom);
    dy = 24'($urandom);
    cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy;
    pix_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ph = 0; pix = 0; post = 0; aclr_seen = 0; done_seen = 0; err_pix = 0; valid_cyc = 0;
    finished = 1'b0;
    err_msg  = "";
    exp_red  = '0;
    exp_blue = '0;
    exp_rz   = model_float(x0);
    exp_iz   = model_float(y0);
    for (int cyc = 0; cyc < FRAME_BUDGET && !finished; cyc++) begin
      aclr_seen += int'(aclr);
      done_seen += int'(done);
      if (pix < NPIX) begin
        exp_count = (ph < CLEAR_CYC) ? 13'd0 :
                    (ph <= CLEAR_CYC + COUNT_MAX) ? 13'(ph - CLEAR_CYC) : 13'(COUNT_MAX);
        valid_cyc += int'(pix_valid);
        if (aclr !== (ph == 0) || count !== exp_count || pix_valid !== (ph >= WRITE_PH) ||
            busy !== 1'b1 || done !== 1'b0) begin
          if (err_pix == 0)
            err_msg = $sformatf("ph=%0d aclr=%b count=%0d valid=%b busy=%b done=%b (need count=%0d)",
                                ph, aclr, count, pix_valid, busy, done, exp_count);
          err_pix++;
        end
        if (ph >= 1 && (rZ !== exp_rz || iZ !== exp_iz)) begin
          if (err_pix == 0)
            err_msg = $sformatf("ph=%0d rZ=%h iZ=%h (need %h %h)", ph, rZ, iZ, exp_rz, exp_iz);
          err_pix++;
        end
        if (ph >= WRITE_PH && {pix_x, pix_y, pix_red, pix_blue} !==
            {10'(pix % H_RES), 9'(pix / H_RES), exp_red, exp_blue}) begin
          if (err_pix == 0)
            err_msg = $sformatf("ph=%0d data x=%0d y=%0d r=%h b=%h changed in WRITE", ph, pix_x, pix_y, pix_red, pix_blue);
          err_pix++;
        end

        red_in  = 8'($urandom);
        blue_in = 8'($urandom);
        if (ph == WRITE_PH - 1) begin
          exp_red  = red_in;
          exp_blue = blue_in;
        end
        start = 1'b0;
        if (stress && pix == 0 && ph == 100) begin
          start  = 1'b1;
          cfg_x0 = 24'($urandom);
          cfg_y0 = 24'($urandom);
          cfg_dx = 24'($urandom);
          cfg_dy = 24'($urandom);
        end
        if (ph >= WRITE_PH)
          pix_ready = !stress ? 1'b1 : (pix == 0) ? (ph - WRITE_PH >= 5) : 1'($urandom_range(0, 1));
        else
          pix_ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;

        if (ph >= WRITE_PH && pix_ready) begin
          total++;
          if (err_pix !== 0) begin
            bad++;
            $display("FAIL %s_timeline_p%0d: %0d bad cycles, first %s", tag, pix, err_pix, err_msg);
          end
          total++;
          if ({rZ, iZ} !== {exp_rz, exp_iz}) begin
            bad++;
            $display("FAIL %s_z_p%0d: got %h %h need %h %h", tag, pix, rZ, iZ, exp_rz, exp_iz);
          end
          total++;
          if ({pix_x, pix_y} !== {10'(pix % H_RES), 9'(pix / H_RES)}) begin
            bad++;
            $display("FAIL %s_coord_p%0d: got (%0d,%0d) need (%0d,%0d)", tag, pix, pix_x, pix_y, pix % H_RES, pix / H_RES);
          end
          total++;
          if ({pix_red, pix_blue} !== {exp_red, exp_blue}) begin
            bad++;
            $display("FAIL %s_colour_p%0d: got %h %h need %h %h", tag, pix, pix_red, pix_blue, exp_red, exp_blue);
          end
          total++;
          if (valid_cyc !== ph - WRITE_PH + 1) begin
            bad++;
            $display("FAIL %s_valid_len_p%0d: got %0d need %0d", tag, pix, valid_cyc, ph - WRITE_PH + 1);
          end
          if (!stress && pix < 2) begin
            total++;
            if (rZ !== step_rz[pix]) begin
              bad++;
              $display("FAIL step_rz_p%0d: got %h need %h", pix, rZ, step_rz[pix]);
            end
          end
          pix++;
          ph        = 0;
          err_pix   = 0;
          valid_cyc = 0;
          exp_rz    = model_float(x0 + 24'(pix % H_RES) * dx);
          exp_iz    = model_float(y0 + 24'(pix / H_RES) * dy);
        end else begin
          ph++;
        end
      end else begin
        start     = 1'b0;
        pix_ready = 1'($urandom_range(0, 1));
        if (post == 0) begin
          total++;
          if ({done, busy, pix_valid} !== 3'b110) begin
            bad++;
            $display("FAIL %s_done_cycle: got done,busy,valid=%b need 110", tag, {done, busy, pix_valid});
          end
        end else if (post == 1) begin
          total++;
          if ({done, busy, pix_valid} !== 3'b000) begin
            bad++;
            $display("FAIL %s_idle_after_done: got done,busy,valid=%b need 000", tag, {done, busy, pix_valid});
          end
        end else if (post == 6) begin
          finished = 1'b1;
        end
        post++;
      end
      if (!finished) @(negedge clk);
    end
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL %s_frame_timeout: got %0d pixels need %0d", tag, pix, NPIX);
    end
    total++;
    if (done_seen !== 1) begin
      bad++;
      $display("FAIL %s_done_pulses: got %0d need 1", tag, done_seen);
    end
    total++;
    if (aclr_seen !== NPIX) begin
      bad++;
      $display("FAIL %s_aclr_pulses: got %0d need %0d", tag, aclr_seen, NPIX);
    end
    pix_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    start     = 1'b0;
    cfg_x0    = '0;
    cfg_y0    = '0;
    cfg_dx    = '0;
    cfg_dy    = '0;
    red_in    = '0;
    blue_in   = '0;
    pix_ready = 1'b0;
    test_reset();
    test_conversion();
    test_frame(1'b0);
    test_frame(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
